regfile_csr: RTL and testbench

Parametrised integer register file with an integrated machine-mode CSR unit for the pipelined core, read in decode and written at writeback. Extends the fixed two-port file with a configurable read-port count, write-first bypass, real CSR read-modify-write ops (RW/RS/RC), illegal-access flagging, and 64-bit cycle/instret counters. A clear state machine zeroes the array after reset instead of a one-cycle loop.

---
 rtl/diagv2_pkg.sv | 21 ++
 rtl/regfile_csr_if.sv | 33 +++
 rtl/regfile_csr_csr_unit.sv | 96 +++++++++
 rtl/regfile_csr.sv | 88 ++++++++
 tb/tb_regfile_csr.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diagv2_pkg.sv
// Shared definitions for the register file / CSR slice: CSR addresses,
// csr_op encodings and the clear-FSM state type.
package diagv2_pkg;

  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  localparam logic [1:0] CSR_NONE = 2'b00;
  localparam logic [1:0] CSR_RW   = 2'b01;
  localparam logic [1:0] CSR_RS   = 2'b10;
  localparam logic [1:0] CSR_RC   = 2'b11;

  // Clear FSM: CLEAR zeroes the array after reset, RUN is normal operation.
  typedef logic [0:0] clr_state_t;
  localparam clr_state_t ST_CLEAR = 1'b0;
  localparam clr_state_t ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_csr_if.sv
// Decode/writeback port bundle of the register file with its CSR unit.
interface regfile_csr_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                  ready;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic                  we;
  logic [AW-1:0]         rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic [1:0]            csr_op;
  logic [11:0]           csr_addr;
  logic [XLEN-1:0]       csr_wdata;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_illegal;
  logic                  retire;

  // Pipeline side drives addresses/data, register file answers.
  modport master (
    input  ready, rs_data, csr_rdata, csr_illegal,
    output rs_addr, we, rd_addr, rd_data, csr_op, csr_addr, csr_wdata, retire
  );

  modport slave (
    output ready, rs_data, csr_rdata, csr_illegal,
    input  rs_addr, we, rd_addr, rd_data, csr_op, csr_addr, csr_wdata, retire
  );

endinterface

// File: rtl/regfile_csr_csr_unit.sv
// Machine-mode CSR unit: address decode, illegal-access check, RW/RS/RC
// read-modify-write datapath, mscratch and the 64-bit cycle/instret counters.
module csr_unit
  import diagv2_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            retire_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o
);

  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic            implemented, read_only, wants_write, illegal, do_write;
  logic [XLEN-1:0] old_val, new_val;

  // With XLEN=32 a write replaces only the low half of a 64-bit counter.
  function automatic logic [63:0] merge_low(logic [63:0] cur, logic [XLEN-1:0] v);
    merge_low = cur;
    merge_low[XLEN-1:0] = v;
  endfunction

  // Decode the address, qualify the access and compute the RMW result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    implemented = 1'b0;
    read_only   = 1'b0;
    old_val     = '0;
    case (csr_addr_i)
      CSR_MSCRATCH: begin implemented = 1'b1; old_val = mscratch_q; end
      CSR_MCYCLE:   begin implemented = 1'b1; old_val = mcycle_q[XLEN-1:0]; end
      CSR_MINSTRET: begin implemented = 1'b1; old_val = minstret_q[XLEN-1:0]; end
      CSR_CYCLE:    begin implemented = 1'b1; read_only = 1'b1; old_val = mcycle_q[XLEN-1:0]; end
      CSR_INSTRET:  begin implemented = 1'b1; read_only = 1'b1; old_val = minstret_q[XLEN-1:0]; end
      default:      ;
    endcase

    // RS/RC with a zero mask is a pure read and never counts as a write.
    wants_write = (csr_op_i == CSR_RW) || (csr_wdata_i != '0);
    illegal     = run_i && (csr_op_i != CSR_NONE) &&
                  (!implemented || (wants_write && read_only));
    do_write    = run_i && (csr_op_i != CSR_NONE) && !illegal && wants_write;

    case (csr_op_i)
      CSR_RW:  new_val = csr_wdata_i;
      CSR_RS:  new_val = old_val | csr_wdata_i;
      CSR_RC:  new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign csr_rdata_o   = (run_i && implemented && !illegal) ? old_val : '0;
  assign csr_illegal_o = illegal;

  // Next state of the CSRs: counters advance, a CSR write in the same cycle wins.
  always_comb begin
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire_i};
    if (!run_i) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end else if (do_write) begin
      case (csr_addr_i)
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MCYCLE:   mcycle_d   = merge_low(mcycle_q, new_val);
        CSR_MINSTRET: minstret_d = merge_low(minstret_q, new_val);
        default:      ;
      endcase
    end
  end

  // CSR state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: rtl/regfile_csr.sv
// Integer register file for the pipelined core: NREAD combinational read
// ports with write-first bypass, one writeback port, a post-reset clear
// sequence, and the machine-mode CSR unit.
module regfile_csr
  import diagv2_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input logic          clk,
  input logic          reset,
  regfile_csr_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  clr_state_t            state_q, state_d;
  logic [AW-1:0]         clr_idx_q, clr_idx_d;
  logic [XLEN-1:0]       gpr_q [NREGS];
  logic                  run;
  logic [NREAD*XLEN-1:0] rs_data_c;

  assign run       = (state_q == ST_RUN);
  assign bus.ready = run;

  // Clear FSM: walk x1..x(NREGS-1) once, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(NREGS - 1)) state_d = ST_RUN;
    end
  end

  // Clear FSM state; reset (even mid-clear) restarts the walk at x1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // GPR array write: clear sequence first, then writeback; x0 is never stored.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the clear sequence zeroes it after reset instead.
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        gpr_q[clr_idx_q] <= '0;
      end else if (bus.we && (bus.rd_addr != '0)) begin
        gpr_q[bus.rd_addr] <= bus.rd_data;
      end
    end
  end

  // Read ports: x0 and CLEAR read zero, a same-cycle write is forwarded.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    rs_data_c = '0;
    for (int k = 0; k < NREAD; k++) begin
      a = bus.rs_addr[k*AW +: AW];
      if (run && (a != '0)) begin
        if (bus.we && (bus.rd_addr == a)) rs_data_c[k*XLEN +: XLEN] = bus.rd_data;
        else                              rs_data_c[k*XLEN +: XLEN] = gpr_q[a];
      end
    end
  end

  assign bus.rs_data = rs_data_c;

  csr_unit #(.XLEN(XLEN)) u_csr (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run),
    .csr_op_i     (bus.csr_op),
    .csr_addr_i   (bus.csr_addr),
    .csr_wdata_i  (bus.csr_wdata),
    .retire_i     (bus.retire),
    .csr_rdata_o  (bus.csr_rdata),
    .csr_illegal_o(bus.csr_illegal)
  );

endmodule

// File: tb/tb_regfile_csr.sv
// Scoreboard bench for regfile_csr: expectations are queued as stimulus is
// driven on the falling edge and compared against the DUT outputs shortly after.
module tb_regfile_csr;
  import diagv2_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_csr_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  regfile_csr #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum int {O_READY, O_RS0, O_RS1, O_RDATA, O_ILL} out_sel_e;
  typedef struct {
    string       tag;
    out_sel_e    sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  bit          model_on = 1'b0;
  bit          m_ready;
  int          m_clr;
  logic [63:0] m_gpr [NREGS];
  logic [63:0] m_mscratch, m_mcycle, m_minstret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input out_sel_e sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input out_sel_e s);
    case (s)
      O_READY: return {63'd0, bus.ready};
      O_RS0:   return bus.rs_data[XLEN-1:0];
      O_RS1:   return bus.rs_data[2*XLEN-1:XLEN];
      O_RDATA: return bus.csr_rdata;
      default: return {63'd0, bus.csr_illegal};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Model read port given the currently driven inputs.
  function automatic logic [63:0] m_rs(input logic [AW-1:0] a);
    if (!m_ready || a == '0) return 64'd0;
    if (bus.we && bus.rd_addr == a) return bus.rd_data;
    return m_gpr[a];
  endfunction

  // Model CSR access given the currently driven inputs.
  task automatic m_csr(output logic ill, output logic wr, output logic [63:0] rdata,
                       output logic [63:0] newv);
    logic        impl, ro, ww;
    logic [63:0] old;
    impl = 1'b1; ro = 1'b0; old = 64'd0;
    case (bus.csr_addr)
      12'h340: old = m_mscratch;
      12'hB00: old = m_mcycle;
      12'hB02: old = m_minstret;
      12'hC00: begin old = m_mcycle;   ro = 1'b1; end
      12'hC02: begin old = m_minstret; ro = 1'b1; end
      default: impl = 1'b0;
    endcase
    ww    = (bus.csr_op == 2'b01) || (bus.csr_wdata != 64'd0);
    ill   = m_ready && (bus.csr_op != 2'b00) && (!impl || (ww && ro));
    wr    = m_ready && (bus.csr_op != 2'b00) && !ill && ww;
    rdata = (m_ready && impl && !ill) ? old : 64'd0;
    case (bus.csr_op)
      2'b01:   newv = bus.csr_wdata;
      2'b10:   newv = old | bus.csr_wdata;
      2'b11:   newv = old & ~bus.csr_wdata;
      default: newv = old;
    endcase
  endtask

  task automatic push_model();
    logic        ill, wr;
    logic [63:0] rdata, newv;
    m_csr(ill, wr, rdata, newv);
    expect_out("m_ready", O_READY, {63'd0, m_ready});
    expect_out("m_rs0", O_RS0, m_rs(bus.rs_addr[AW-1:0]));
    expect_out("m_rs1", O_RS1, m_rs(bus.rs_addr[2*AW-1:AW]));
    expect_out("m_csr_rdata", O_RDATA, rdata);
    expect_out("m_csr_illegal", O_ILL, {63'd0, ill});
  endtask

  // Advance the model across the upcoming rising edge.
  task automatic model_edge();
    logic        ill, wr;
    logic [63:0] rdata, newv, mc, mi;
    if (reset) begin
      m_ready = 1'b0; m_clr = 1;
      m_mscratch = '0; m_mcycle = '0; m_minstret = '0;
      for (int i = 0; i < NREGS; i++) m_gpr[i] = '0;
    end else if (!m_ready) begin
      if (m_clr == NREGS - 1) m_ready = 1'b1;
      m_clr++;
    end else begin
      if (bus.we && bus.rd_addr != '0) m_gpr[bus.rd_addr] = bus.rd_data;
      m_csr(ill, wr, rdata, newv);
      mc = m_mcycle + 64'd1;
      mi = m_minstret + {63'd0, bus.retire};
      if (wr) begin
        case (bus.csr_addr)
          12'h340: m_mscratch = newv;
          12'hB00: mc = newv;
          12'hB02: mi = newv;
          default: ;
        endcase
      end
      m_mcycle = mc; m_minstret = mi;
    end
  endtask

  task automatic cycle();
    if (model_on) push_model();
    #2 drain();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.rd_addr = '0; bus.rd_data = '0;
    bus.csr_op = CSR_NONE; bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.retire = 1'b0; bus.rs_addr = '0;
  endtask

  task automatic rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rs_addr = {a1, a0};
  endtask

  task automatic gpr_wr(input logic [AW-1:0] rd, input logic [63:0] d);
    bus.we = 1'b1; bus.rd_addr = rd; bus.rd_data = d;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] w);
    bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = w;
  endtask

  // Hold reset low through a whole clear, checking ready/rs_data each cycle.
  task automatic run_clear(input string tag);
    for (int e = 1; e < NREGS; e++) begin
      idle();
      rs(AW'(e), AW'(e * 7));
      gpr_wr(AW'(e + 3), 64'hBAD0_0000_0000_0000 | 64'(e));
      bus.retire = 1'b1;
      if (e % 2 == 0) csr(CSR_RW, 12'h7C0, 64'd1);
      else            csr(CSR_RS, CSR_MCYCLE, 64'd0);
      expect_out({tag, "_ready"}, O_READY, 64'd0);
      expect_out({tag, "_rs0"}, O_RS0, 64'd0);
      expect_out({tag, "_rdata"}, O_RDATA, 64'd0);
      expect_out({tag, "_ill"}, O_ILL, 64'd0);
      cycle();
    end
    idle();
    expect_out({tag, "_ready_up"}, O_READY, 64'd1);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < NREGS; a += 2) begin
      idle();
      rs(AW'(a), AW'(a + 1));
      if (a == 0) csr(CSR_RS, CSR_MCYCLE, 64'd0);
      if (a == 2) csr(CSR_RS, CSR_MINSTRET, 64'd0);
      if (a <= 2) expect_out({tag, "_ctr_zero"}, O_RDATA, 64'd0);
      expect_out({tag, "_rs0_zero"}, O_RS0, 64'd0);
      expect_out({tag, "_rs1_zero"}, O_RS1, 64'd0);
      cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    cycle();               // first reset edge settles state; nothing defined to compare yet
    model_on = 1'b1;

    // Reset held with live traffic: outputs stay quiet.
    rs(5, 7); gpr_wr(5, 64'hAA); csr(CSR_RW, 12'h7C0, 64'd1); bus.retire = 1'b1;
    expect_out("rst_ready", O_READY, 64'd0);
    expect_out("rst_rs0", O_RS0, 64'd0);
    expect_out("rst_rdata", O_RDATA, 64'd0);
    expect_out("rst_ill", O_ILL, 64'd0);
    cycle();
    reset = 1'b0;

    run_clear("clr");
    read_all_zero("clr");

    // GPR write with same-cycle bypass, x0 stays zero.
    idle(); rs(5, 6); gpr_wr(5, 64'hDEAD_BEEF);
    expect_out("byp_rs0", O_RS0, 64'hDEAD_BEEF);
    expect_out("byp_rs1_other", O_RS1, 64'd0);
    cycle();
    idle(); rs(0, 5); gpr_wr(0, 64'h1234);
    expect_out("x0_byp", O_RS0, 64'd0);
    expect_out("x5_stored", O_RS1, 64'hDEAD_BEEF);
    cycle();
    idle(); rs(0, 0);
    expect_out("x0_after", O_RS0, 64'd0);
    cycle();
    idle(); rs(9, 9); gpr_wr(9, 64'hCAFE_F00D_0000_0001);
    expect_out("byp2_rs0", O_RS0, 64'hCAFE_F00D_0000_0001);
    expect_out("byp2_rs1", O_RS1, 64'hCAFE_F00D_0000_0001);
    cycle();
    idle(); rs(9, 5);
    expect_out("x9_stored", O_RS0, 64'hCAFE_F00D_0000_0001);
    expect_out("x5_kept", O_RS1, 64'hDEAD_BEEF);
    cycle();

    // Counters: zero both, then 10 cycles with 4 retires.
    idle(); csr(CSR_RW, CSR_MINSTRET, 64'd0); cycle();
    idle(); csr(CSR_RW, CSR_MCYCLE, 64'd0); cycle();
    for (int i = 0; i < 10; i++) begin
      idle();
      bus.retire = (i % 3 == 0);
      cycle();
    end
    idle(); csr(CSR_RS, CSR_MCYCLE, 64'd0);
    expect_out("mcycle_10", O_RDATA, 64'd10);
    cycle();
    idle(); csr(CSR_RS, CSR_MINSTRET, 64'd0);
    expect_out("minstret_4", O_RDATA, 64'd4);
    cycle();
    idle(); csr(CSR_RW, CSR_MCYCLE, '1); cycle();
    idle(); cycle();
    idle(); csr(CSR_RS, CSR_MCYCLE, 64'd0);
    expect_out("mcycle_wrap", O_RDATA, 64'd0);
    cycle();
    idle(); csr(CSR_RW, CSR_MINSTRET, 64'd100); bus.retire = 1'b1; cycle();
    idle(); csr(CSR_RS, CSR_MINSTRET, 64'd0);
    expect_out("minstret_write_wins", O_RDATA, 64'd100);
    cycle();

    // mscratch set/clear read-modify-write.
    idle(); csr(CSR_RW, CSR_MSCRATCH, 64'hF0); cycle();
    idle(); csr(CSR_RS, CSR_MSCRATCH, 64'h0F);
    expect_out("rs_old", O_RDATA, 64'hF0);
    cycle();
    idle(); csr(CSR_RS, CSR_MSCRATCH, 64'd0);
    expect_out("rs_new", O_RDATA, 64'hFF);
    cycle();
    idle(); csr(CSR_RC, CSR_MSCRATCH, 64'hF0);
    expect_out("rc_old", O_RDATA, 64'hFF);
    cycle();
    idle(); csr(CSR_RS, CSR_MSCRATCH, 64'd0);
    expect_out("rc_new", O_RDATA, 64'h0F);
    cycle();
    idle(); csr(CSR_RS, CSR_CYCLE, 64'd0);
    expect_out("cycle_ro_read_legal", O_ILL, 64'd0);
    expect_out("cycle_alias", O_RDATA, m_mcycle);
    cycle();
    idle(); csr(CSR_RC, CSR_INSTRET, 64'd0);
    expect_out("instret_ro_read_legal", O_ILL, 64'd0);
    expect_out("instret_alias", O_RDATA, 64'd100);
    cycle();

    // Illegal accesses: flagged, read zero, change nothing.
    idle(); csr(CSR_RW, CSR_INSTRET, 64'h55);
    expect_out("ill_rw_ro", O_ILL, 64'd1);
    expect_out("ill_rw_ro_rdata", O_RDATA, 64'd0);
    cycle();
    idle(); csr(CSR_RS, CSR_CYCLE, 64'd1);
    expect_out("ill_rs_ro", O_ILL, 64'd1);
    cycle();
    idle(); csr(CSR_RS, 12'h7C0, 64'd0);
    expect_out("ill_unimpl", O_ILL, 64'd1);
    expect_out("ill_unimpl_rdata", O_RDATA, 64'd0);
    cycle();
    idle(); csr(CSR_RW, 12'h7C0, 64'hFFFF);
    expect_out("ill_unimpl_rw", O_ILL, 64'd1);
    cycle();
    idle(); csr(CSR_NONE, 12'h7C0, 64'd0);
    expect_out("none_not_ill", O_ILL, 64'd0);
    cycle();
    idle(); csr(CSR_RS, CSR_MINSTRET, 64'd0);
    expect_out("ill_minstret_kept", O_RDATA, 64'd100);
    cycle();
    idle(); csr(CSR_RS, CSR_MSCRATCH, 64'd0);
    expect_out("ill_mscratch_kept", O_RDATA, 64'h0F);
    cycle();

    // Preload garbage, reset, abort the clear at clr_idx=12 and restart it.
    for (int r = 1; r < NREGS; r++) begin
      idle(); gpr_wr(AW'(r), 64'hBAD0_BAD0_0000_0000 | 64'(r)); cycle();
    end
    idle(); reset = 1'b1; cycle();
    reset = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      idle(); rs(AW'(e), AW'(e + 12));
      expect_out("mid_ready", O_READY, 64'd0);
      cycle();
    end
    idle(); reset = 1'b1; cycle();
    reset = 1'b0;
    run_clear("reclr");
    read_all_zero("reclr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
